// File: rtl/l2_cacheline_adapter_pkg.sv
// Shared types and geometry for the L2 line <-> 64-bit burst adapter.
package l2_adapter_pkg;

  localparam int S_OFFSET  = 5;
  localparam int S_LINE    = 256;
  localparam int S_BURST   = 64;
  localparam int NUM_BEATS = S_LINE / S_BURST;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_e;

  typedef logic [1:0] beat_t;

  // A line viewed as beats; beat k occupies bits [64*k+63 : 64*k].
  typedef logic [NUM_BEATS-1:0][S_BURST-1:0] line_t;

  localparam beat_t LAST_BEAT = beat_t'(NUM_BEATS - 1);

  function automatic logic [31:0] lineAlign(input logic [31:0] addr);
    logic [31:0] aligned;
    aligned = addr;
    aligned[S_OFFSET-1:0] = '0;
    return aligned;
  endfunction

endpackage

// File: rtl/l2_cacheline_adapter_if.sv
// L2-side line handshake plus memory-side burst bus, named from the adapter's view.
interface l2_cacheline_adapter_if;
  import l2_adapter_pkg::*;

  logic [31:0]        address_i;
  logic [S_LINE-1:0]  line_i;
  logic [S_LINE-1:0]  line_o;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [31:0]        address_o;
  logic [S_BURST-1:0] burst_i;
  logic [S_BURST-1:0] burst_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  modport slave (
    input  address_i, line_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, address_o, burst_o, read_o, write_o
  );

  modport master (
    output address_i, line_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, address_o, burst_o, read_o, write_o
  );

endinterface

// File: rtl/l2_cacheline_adapter.sv
// Turns L2 line reads/writebacks into 4-beat 64-bit memory bursts with a single resp pulse back to L2.
module l2_cacheline_adapter
  import l2_adapter_pkg::*;
(
  input logic                    clk,
  input logic                    rst,
  l2_cacheline_adapter_if.slave  bus
);

  state_e       state_q;
  beat_t        beat_q;
  logic [31:0]  addr_q;
  line_t        wrLine_q;
  line_t        rdLine_q;
  logic         read_q;
  logic         write_q;
  logic         resp_q;

  // Outputs are registered alongside the state so read_o/write_o track the upcoming state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      addr_q   <= '0;
      wrLine_q <= '0;
      rdLine_q <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      resp_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.write_i || bus.read_i) begin
            addr_q   <= lineAlign(bus.address_i);
            wrLine_q <= bus.line_i;
            beat_q   <= '0;
            if (bus.write_i) begin
              state_q <= WR;
              write_q <= 1'b1;
            end else begin
              state_q <= RD;
              read_q  <= 1'b1;
            end
          end
        end
        RD: begin
          if (bus.resp_i) begin
            rdLine_q[beat_q] <= bus.burst_i;
            if (beat_q == LAST_BEAT) begin
              state_q <= DONE;
              read_q  <= 1'b0;
              resp_q  <= 1'b1;
            end else begin
              beat_q <= beat_q + beat_t'(1);
            end
          end
        end
        WR: begin
          if (bus.resp_i) begin
            if (beat_q == LAST_BEAT) begin
              state_q <= DONE;
              write_q <= 1'b0;
              resp_q  <= 1'b1;
            end else begin
              beat_q <= beat_q + beat_t'(1);
            end
          end
        end
        DONE: begin
          // Requests are deliberately not sampled here so a still-held request is not replayed.
          resp_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.address_o = addr_q;
  assign bus.read_o    = read_q;
  assign bus.write_o   = write_q;
  assign bus.resp_o    = resp_q;
  assign bus.line_o    = rdLine_q;
  assign bus.burst_o   = write_q ? wrLine_q[beat_q] : '0;

endmodule

// File: doc/l2_cacheline_adapter.md
Name: l2_cacheline_adapter

Overview:
- Sits directly downstream of the L2 cache, between its 256-bit line port and the 64-bit burst physical-memory bus.
- Converts each L2 line read into a 4-beat burst read, assembling the beats into one 256-bit line.
- Converts each L2 line writeback into a 4-beat burst write, slicing the line into beats.
- Presents a single request/response handshake toward the L2 controller.

Parameters:
- s_offset, 5, byte-offset bits per line; address_o low s_offset bits forced to 0
- s_line, 256, line width in bits
- s_burst, 64, burst beat width in bits
- num_beats, s_line/s_burst (4), beats per line

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- address_i  input  32  line address from L2
- line_i  input  256  writeback line from L2
- line_o  output  256  assembled read line to L2
- read_i  input  1  L2 line read request
- write_i  input  1  L2 line write request
- resp_o  output  1  one-cycle completion pulse to L2
- address_o  output  32  burst address to memory
- burst_i  input  64  read beat from memory
- burst_o  output  64  write beat to memory
- read_o  output  1  burst read request
- write_o  output  1  burst write request
- resp_i  input  1  memory beat strobe; one beat per high cycle

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; beat counter = 0.
  - read_o, write_o and resp_o = 0.
  - address_o, burst_o and line_o = 0.
  - Reset mid-burst abandons the transaction and produces no resp_o.
- State machine: IDLE, RD, WR, DONE.
- IDLE:
  - Samples read_i/write_i.
  - On a request, latches address_i (low 5 bits cleared) and line_i, and clears the beat counter.
  - write_i -> WR; read_i -> RD. If both are high, the write has priority.
  - No request -> stays in IDLE.
- RD:
  - read_o = 1.
  - Each cycle resp_i = 1: burst_i is stored into line bits [64*k+63 : 64*k], where k is the beat counter, then k increments.
  - resp_i gaps are legal; state and counter hold.
  - On the beat with k = 3 -> DONE.
- WR:
  - write_o = 1; burst_o = latched line[64*k+63 : 64*k].
  - Each resp_i = 1 increments k.
  - On the beat with k = 3 -> DONE.
- DONE:
  - resp_o = 1 for exactly one cycle; next state is IDLE.
  - read_o and write_o are 0.
  - Requests are not sampled in DONE. This prevents a stale, still-asserted request from being re-issued.
- Handshake outputs:
  - read_o/write_o are registered from the next state: high from the cycle after acceptance through the cycle the 4th resp_i is sampled.
  - address_o is held constant for the whole burst.
- Latency:
  - Request accepted at cycle N; read_o/write_o high at N+1.
  - With back-to-back resp_i at N+1..N+4, resp_o is high at N+5.
- line_o:
  - Valid while resp_o is high.
  - Held unchanged until the next read's first beat.
  - Writes never alter line_o.
- Inputs read_i, write_i, address_i and line_i are ignored outside IDLE.
- resp_i in IDLE or DONE is ignored.
- The beat counter is 2 bits and stops at the DONE transition; it never wraps inside a burst.

Decomposition:
- Package l2_adapter_pkg holds:
  - state enum (IDLE, RD, WR, DONE)
  - constants S_LINE = 256, S_BURST = 64, NUM_BEATS = 4, S_OFFSET = 5
  - beat index type logic [1:0]
- No sub-module. A single FSM plus line/address registers is natural.

Test Plan:
- Read, back-to-back beats: read_i at address 0x0000_1234. Memory returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 on four consecutive resp_i.
  - Expect address_o = 0x0000_1220 and read_o high for 4 cycles.
  - Expect resp_o exactly 1 cycle later with line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write: write_i with line_i = {D3, D2, D1, D0} at 0x0000_8040.
  - Expect burst_o = D0, D1, D2, D3 on successive resp_i.
  - Expect write_o high throughout the burst, then resp_o one cycle; line_o unchanged.
- Gapped beats: resp_i pattern 1,0,0,1,1,0,1 during a read.
  - Expect beats assembled only on high cycles and resp_o one cycle after the 7th cycle.
- Simultaneous read_i & write_i in IDLE: expect write_o (not read_o), a write burst, and a single resp_o.
- Reset mid-burst: assert rst low after 2 beats of a read.
  - Expect immediate read_o = 0, line_o = 0, no resp_o.
  - A following read completes normally.
- Held request after resp_o: keep read_i high through DONE. Expect no new read_o in the DONE cycle; a new burst starts only after IDLE re-samples.
